fifo_word_packer: RTL and testbench

Downstream consumer of the 8-bit test FIFO. It drains a commanded number of bytes, assembles them into big-endian 32-bit words and hands each word to a valid/ready sink, flagging the last word of the transfer. Benches use it to feed byte streams (USB/SD data paths) into 32-bit bus models. Reads honour the FIFO's one-cycle read latency and never over-read.

---
 rtl/fifo_word_packer_pkg.sv | 29 ++
 rtl/fifo_word_packer.sv | 127 ++++++++++++
 tb/tb_fifo_word_packer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared types and helpers for the byte-to-word FIFO packer.
package fifo_word_packer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned SLOT_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    OUTPUT,
    DONE
  } state_t;

  // Write one byte into the big-endian lane selected by slot (slot 0 -> [31:24]).
  function automatic logic [31:0] pack_lane(input logic [31:0]       word,
                                            input logic [SLOT_W-1:0] slot,
                                            input logic [7:0]        data);
    logic [31:0] r;
    r = word;
    case (slot)
      2'd0:    r[31:24] = data;
      2'd1:    r[23:16] = data;
      2'd2:    r[15:8]  = data;
      default: r[7:0]   = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drains a commanded number of bytes from an 8-bit FIFO (one-cycle read
// latency) and presents them as big-endian 32-bit words on a valid/ready sink.
module fifo_word_packer #(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_BITS-1:0] length,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  input  logic                fifo_empty,
  output logic                fifo_read,
  input  logic [7:0]          fifo_rdata,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [31:0]         word_data,
  output logic [2:0]          word_bytes,
  output logic                word_last
);
  import fifo_word_packer_pkg::*;

  state_t              state;
  state_t              state_nxt;
  logic [LEN_BITS-1:0] remaining;
  logic [2:0]          issued;
  logic [2:0]          captured;
  logic [2:0]          target;
  logic                rd_pending;
  logic                capture_last;
  logic [31:0]         data_q;
  logic [2:0]          bytes_q;

  // Bytes wanted for the word being filled: up to a full word, never past the end.
  always_comb begin
    if (remaining >= LEN_BITS'(WORD_BYTES)) target = 3'(WORD_BYTES);
    else                                    target = remaining[2:0];
  end

  assign capture_last = rd_pending && ((captured + 3'd1) == target);

  // Next-state and FIFO read strobe.
  always_comb begin
    state_nxt = state;
    fifo_read = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = (length == '0) ? DONE : FILL;
      end
      FILL: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          fifo_read = !fifo_empty && (issued < target);
          if (capture_last) state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (abort)           state_nxt = IDLE;
        else if (word_ready) state_nxt = (remaining == '0) ? DONE : FILL;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status and sink outputs decoded from the current state.
  always_comb begin
    busy       = (state == FILL) || (state == OUTPUT);
    done       = (state == DONE);
    word_valid = (state == OUTPUT);
    word_last  = (state == OUTPUT) && (remaining == '0);
    word_data  = data_q;
    word_bytes = bytes_q;
  end

  // State register, byte counters and packing register.
  // A byte returned in a cycle that aborts is deliberately not captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      issued     <= '0;
      captured   <= '0;
      rd_pending <= 1'b0;
      data_q     <= '0;
      bytes_q    <= '0;
    end else begin
      state      <= state_nxt;
      rd_pending <= fifo_read;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            remaining <= length;
            issued    <= '0;
            captured  <= '0;
            data_q    <= '0;
            bytes_q   <= '0;
          end
        end
        FILL: begin
          if (!abort) begin
            if (fifo_read) issued <= issued + 3'd1;
            if (rd_pending) begin
              data_q   <= pack_lane(data_q, captured[SLOT_W-1:0], fifo_rdata);
              captured <= captured + 3'd1;
            end
            if (capture_last) begin
              remaining <= remaining - LEN_BITS'(target);
              bytes_q   <= target;
            end
          end
        end
        OUTPUT: begin
          if (!abort && word_ready && (remaining != '0)) begin
            issued   <= '0;
            captured <= '0;
            data_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer with a behavioural FIFO and word model.
module tb_fifo_word_packer;

  localparam int LEN_BITS = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [LEN_BITS-1:0] length;
  logic                abort;
  logic                busy;
  logic                done;
  logic                fifo_empty;
  logic                fifo_read;
  logic [7:0]          fifo_rdata = 8'h00;
  logic                word_valid;
  logic                word_ready;
  logic [31:0]         word_data;
  logic [2:0]          word_bytes;
  logic                word_last;

  always #5 clk = ~clk;

  fifo_word_packer #(.LEN_BITS(LEN_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_rdata (fifo_rdata),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_last  (word_last)
  );

  // FIFO model: bench writes at wr_ptr, read strobe pops at rd_ptr, data next cycle.
  logic [7:0]  fmem [0:4095];
  int unsigned wr_ptr    = 0;
  int unsigned rd_ptr    = 0;
  int unsigned overreads = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      if (wr_ptr == rd_ptr) begin
        overreads <= overreads + 1;
      end else begin
        fifo_rdata <= fmem[rd_ptr % 4096];
        rd_ptr     <= rd_ptr + 1;
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nb;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  xfer[$];
  int unsigned feed_idx;
  int unsigned done_cnt = 0;
  int unsigned n_total  = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    else n_pass++;
  endtask

  // Reference: chop the transfer bytes into 4-byte big-endian groups.
  task automatic model_words();
    int unsigned n;
    exp_t        e;
    n = xfer.size();
    for (int unsigned i = 0; i < n; i += 4) begin
      e.data = '0;
      e.nb   = 3'((n - i) >= 4 ? 4 : (n - i));
      for (int unsigned j = 0; j < e.nb; j++) e.data[31 - 8*j -: 8] = xfer[i + j];
      e.last = (i + 4 >= n);
      sb.push_back(e);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fmem[wr_ptr % 4096] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic preload();
    foreach (xfer[i]) push_byte(xfer[i]);
    feed_idx = xfer.size();
  endtask

  task automatic rand_xfer(input int unsigned n);
    xfer.delete();
    for (int unsigned i = 0; i < n; i++) xfer.push_back(8'($urandom));
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int unsigned len);
    start  = 1'b1;
    length = LEN_BITS'(len);
    tick(1);
    start  = 1'b0;
  endtask

  // Run until one done pulse, optionally feeding bytes and toggling ready at random.
  task automatic wait_done(input int unsigned budget, input bit rnd);
    int unsigned d0;
    int unsigned c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < budget) begin
      if (rnd) begin
        word_ready = 1'($urandom_range(0, 1));
        if (feed_idx < xfer.size() && $urandom_range(0, 2) != 0) begin
          push_byte(xfer[feed_idx]);
          feed_idx++;
        end
      end
      tick(1);
      c++;
    end
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  // Monitor: compare every presented word against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt <= done_cnt + 1;
      if (word_valid) begin
        chk("no_read_in_output", 32'(fifo_read), 0);
        chk("word_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("word_data", word_data, sb[0].data);
          chk("word_bytes", 32'(word_bytes), 32'(sb[0].nb));
          chk("word_last", 32'(word_last), 32'(sb[0].last));
          if (word_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned r0;
    int unsigned n;
    int unsigned d0;

    reset = 1'b1; start = 1'b0; length = '0; abort = 1'b0; word_ready = 1'b0;
    feed_idx = 0;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_read", 32'(fifo_read), 0);
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_last", 32'(word_last), 0);
    chk("rst_data", word_data, 0);
    chk("rst_bytes", 32'(word_bytes), 0);
    reset = 1'b0;
    tick(2);

    // Eight bytes, sink always ready; first word latency.
    xfer = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    preload(); model_words();
    word_ready = 1'b1; r0 = rd_ptr;
    do_start(8);
    chk("busy_after_start", 32'(busy), 1);
    n = 0;
    while (!word_valid && n < 20) begin tick(1); n++; end
    chk("first_word_latency", n, 5);
    wait_done(100, 0);
    chk("reads_len8", rd_ptr - r0, 8);
    chk("sb_empty_len8", sb.size(), 0);
    chk("busy_after_done", 32'(busy), 0);

    // Five bytes: partial last word, no over-read.
    xfer = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    preload(); model_words();
    r0 = rd_ptr;
    do_start(5);
    wait_done(100, 0);
    chk("reads_len5", rd_ptr - r0, 5);
    chk("fifo_left_len5", wr_ptr - rd_ptr, 0);
    chk("sb_empty_len5", sb.size(), 0);

    // Zero length: done the cycle after start, nothing else.
    r0 = rd_ptr;
    do_start(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    tick(1);
    chk("zero_done_drop", 32'(done), 0);
    tick(2);
    chk("zero_reads", rd_ptr - r0, 0);

    // Starved FIFO: one byte every three cycles.
    rand_xfer(4); model_words(); feed_idx = 4;
    r0 = rd_ptr;
    do_start(4);
    for (int unsigned i = 0; i < 4; i++) begin
      push_byte(xfer[i]);
      if (i < 3) tick(3);
    end
    n = 0;
    while (!word_valid && n < 20) begin tick(1); n++; end
    chk("starved_latency", n, 2);
    wait_done(100, 0);
    chk("reads_starved", rd_ptr - r0, 4);
    chk("overreads_starved", overreads, 0);

    // Sink stalls for ten cycles; a start during the stall is ignored.
    rand_xfer(8); preload(); model_words();
    word_ready = 1'b0; r0 = rd_ptr;
    do_start(8);
    n = 0;
    while (!word_valid && n < 40) begin tick(1); n++; end
    chk("stall_valid", 32'(word_valid), 1);
    chk("stall_reads_before", rd_ptr - r0, 4);
    d0 = done_cnt;
    for (int unsigned i = 0; i < 10; i++) begin
      start  = (i == 4);
      length = LEN_BITS'(3);
      tick(1);
    end
    start = 1'b0;
    chk("stall_reads_held", rd_ptr - r0, 4);
    chk("stall_valid_held", 32'(word_valid), 1);
    word_ready = 1'b1;
    wait_done(100, 0);
    tick(5);
    chk("stall_reads_total", rd_ptr - r0, 8);
    chk("start_while_busy_ignored", done_cnt - d0, 1);
    chk("stall_idle", 32'(busy), 0);

    // Abort after two bytes of an eight-byte transfer.
    rand_xfer(8); preload();
    r0 = rd_ptr; d0 = done_cnt;
    do_start(8);
    tick(2);
    abort = 1'b1;
    #1;
    chk("abort_read_suppressed", 32'(fifo_read), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(word_valid), 0);
    tick(6);
    chk("abort_reads", rd_ptr - r0, 2);
    chk("abort_no_done", done_cnt - d0, 0);
    wr_ptr = rd_ptr;

    // Reset in the middle of FILL.
    rand_xfer(3); preload();
    do_start(8);
    tick(4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_read", 32'(fifo_read), 0);
    chk("mid_rst_valid", 32'(word_valid), 0);
    chk("mid_rst_data", word_data, 0);
    chk("mid_rst_bytes", 32'(word_bytes), 0);
    chk("mid_rst_done", 32'(done), 0);
    tick(2);
    reset = 1'b0;
    wr_ptr = rd_ptr;
    tick(2);

    // Random transfers with random FIFO arrival and sink backpressure.
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 19);
      rand_xfer(n); model_words(); feed_idx = 0;
      r0 = rd_ptr;
      do_start(n);
      wait_done(2000, 1);
      chk("rand_reads", rd_ptr - r0, n);
      chk("rand_sb_empty", sb.size(), 0);
      word_ready = 1'b1;
      tick(2);
    end

    chk("no_overreads", overreads, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
